// File: rtl/axi_pkg.sv
// Shared definitions for the two-master AXI write arbiter: FSM states,
// AW/W bundle field layout and response constants.
package axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

  // AW bundle, LSB first: AWBURST[1:0], AWSIZE[2:0], AWLEN[7:0], then AWADDR to the MSB.
  localparam int AW_LEN_LSB  = 5;
  localparam int AW_LEN_W    = 8;
  localparam int AW_ADDR_LSB = 13;

  // W bundle: WDATA from bit 0, WLAST is the single bit directly above the data.
  localparam int W_META_W = 1;

  localparam logic BRESP_OKAY = 1'b0;

  // One bit wider than AWLEN so a full 256-beat burst still counts exactly.
  localparam int BEAT_CNT_W = 9;

  function automatic logic [AW_LEN_W-1:0] aw_len(input logic [AW_ADDR_LSB-1:0] aw_ctl);
    return aw_ctl[AW_LEN_LSB +: AW_LEN_W];
  endfunction

endpackage

// File: rtl/axi_wr_arbiter_if.sv
// Bus bundle around the write arbiter: two upstream masters and one downstream slave.
// slave = the arbiter's own view; master = the surrounding agents that drive it.
interface axi_wr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import axi_pkg::*;

  localparam int AW_W = ADDR_W + AW_ADDR_LSB;
  localparam int W_W  = DATA_W + W_META_W;

  logic [1:0][AW_W-1:0] M_AW;
  logic [1:0]           M_AWVALID;
  logic [1:0]           M_AWREADY;
  logic [1:0][W_W-1:0]  M_W;
  logic [1:0]           M_WVALID;
  logic [1:0]           M_WREADY;
  logic [1:0]           M_BRESP;
  logic [1:0]           M_BVALID;
  logic [1:0]           M_BREADY;

  logic [AW_W-1:0]      S_AW;
  logic                 S_AWVALID;
  logic                 S_AWREADY;
  logic [W_W-1:0]       S_W;
  logic                 S_WVALID;
  logic                 S_WREADY;
  logic                 S_BRESP;
  logic                 S_BVALID;
  logic                 S_BREADY;

  modport slave (
    input  M_AW, M_AWVALID, M_W, M_WVALID, M_BREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    output M_AWREADY, M_WREADY, M_BRESP, M_BVALID,
    output S_AW, S_AWVALID, S_W, S_WVALID, S_BREADY
  );

  modport master (
    output M_AW, M_AWVALID, M_W, M_WVALID, M_BREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    input  M_AWREADY, M_WREADY, M_BRESP, M_BVALID,
    input  S_AW, S_AWVALID, S_W, S_WVALID, S_BREADY
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, on contention the
// master that did not own the slave last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-master AXI write arbiter: one whole write transaction (AW, W burst, B)
// owns the slave from grant until its response handshake.
module axi_wr_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  axi_wr_arbiter_if.slave        bus,
  output logic [1:0]             GNT,
  output logic                   ERR
);

  localparam int AW_W = ADDR_W + AW_ADDR_LSB;
  localparam int W_W  = DATA_W + W_META_W;

  wr_state_e             state_q, state_d;
  logic [1:0]            gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic [BEAT_CNT_W-1:0] beat_q, beat_d;
  logic [AW_LEN_W-1:0]   awlen_q, awlen_d;
  logic                  err_q, err_d;

  logic [1:0]            arb_gnt;
  logic                  gnt_idx;
  logic [AW_W-1:0]       sel_aw;
  logic [W_W-1:0]        sel_w;
  logic                  aw_hs, w_hs, b_hs;
  logic [BEAT_CNT_W-1:0] beat_inc;

  rr_arb2 u_rr_arb2 (
    .req  (bus.M_AWVALID),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  // gnt_q is one-hot whenever it is non-zero, so bit 1 alone names the owner.
  assign gnt_idx = gnt_q[1];
  assign sel_aw  = bus.M_AW[gnt_idx];
  assign sel_w   = bus.M_W[gnt_idx];

  assign aw_hs = bus.M_AWVALID[gnt_idx] && bus.S_AWREADY;
  assign w_hs  = bus.M_WVALID[gnt_idx]  && bus.S_WREADY;
  assign b_hs  = bus.S_BVALID           && bus.M_BREADY[gnt_idx];

  // Saturate so an over-long burst can never wrap back onto a matching count.
  assign beat_inc = (beat_q == {BEAT_CNT_W{1'b1}}) ? beat_q : beat_q + 1'b1;

  // NOTE: every variable driven here gets a default before the case, so no
  // path through the state decode can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    beat_d        = beat_q;
    awlen_d       = awlen_q;
    err_d         = 1'b0;

    bus.M_AWREADY = 2'b00;
    bus.M_WREADY  = 2'b00;
    bus.M_BVALID  = 2'b00;
    bus.M_BRESP   = {BRESP_OKAY, BRESP_OKAY};
    bus.S_AW      = '0;
    bus.S_AWVALID = 1'b0;
    bus.S_W       = '0;
    bus.S_WVALID  = 1'b0;
    bus.S_BREADY  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|bus.M_AWVALID) begin
          gnt_d   = arb_gnt;
          state_d = ST_ADDR;
        end
      end

      // A master dropping AWVALID here simply stalls; ownership is already decided.
      ST_ADDR: begin
        bus.S_AW               = sel_aw;
        bus.S_AWVALID          = bus.M_AWVALID[gnt_idx];
        bus.M_AWREADY[gnt_idx] = bus.S_AWREADY;
        if (aw_hs) begin
          awlen_d = aw_len(sel_aw[AW_ADDR_LSB-1:0]);
          beat_d  = '0;
          state_d = ST_DATA;
        end
      end

      // Beats beyond AWLEN+1 keep flowing until WLAST; only the count is judged.
      ST_DATA: begin
        bus.S_W               = sel_w;
        bus.S_WVALID          = bus.M_WVALID[gnt_idx];
        bus.M_WREADY[gnt_idx] = bus.S_WREADY;
        if (w_hs) begin
          beat_d = beat_inc;
          if (sel_w[DATA_W]) begin
            err_d   = (beat_inc != ({1'b0, awlen_q} + 9'd1));
            state_d = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        bus.M_BVALID[gnt_idx] = bus.S_BVALID;
        bus.M_BRESP[gnt_idx]  = bus.S_BRESP;
        bus.S_BREADY          = bus.M_BREADY[gnt_idx];
        if (b_hs) begin
          last_d  = gnt_idx;
          gnt_d   = 2'b00;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      beat_q  <= '0;
      awlen_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      awlen_q <= awlen_d;
      err_q   <= err_d;
    end
  end

  assign GNT = gnt_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized bench for axi_wr_arbiter: master/slave agents plus a transaction-level
// scoreboard and arbitration model that predicts owners, forwarding and ERR.
module tb_axi_wr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] gnt;
  logic       err;

  int checks = 0;
  int errors = 0;

  int rdy_pct    = 100;
  int bubble_pct = 0;

  logic [44:0] exp_aw [2][$];
  logic [32:0] exp_w  [2][$];
  int          owner_log [$];
  int          w_total   = 0;
  int          err_cnt   = 0;

  axi_wr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_wr_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .GNT   (gnt),
    .ERR   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner of an IDLE-cycle arbitration from the request set and the previous owner.
  function automatic logic [1:0] pick(input logic [1:0] req, input int last_owner);
    if (req == 2'b11) return (last_owner == 0) ? 2'b10 : 2'b01;
    return req;
  endfunction

  // Entered at negedge+1 (after drives); returns at negedge+1 when the channel is ready.
  task automatic wait_hs(input int m, input int ch, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if ((ch == 0 && bus.M_AWREADY[m]) || (ch == 1 && bus.M_WREADY[m]) ||
          (ch == 2 && bus.M_BVALID[m])) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("hs_done", 64'(ok), 64'd1);
  endtask

  // One complete write from master m; entered and left at a negedge.
  task automatic m_txn(input int m, input logic [31:0] addr, input logic [7:0] len,
                       input int nbeats);
    logic [44:0] aw;
    logic [32:0] w;
    bit ok;
    aw = {addr, len, 3'($urandom_range(7)), 2'($urandom_range(2))};
    exp_aw[m].push_back(aw);
    bus.M_AW[m]      = aw;
    bus.M_AWVALID[m] = 1'b1;
    wait_hs(m, 0, ok);
    @(negedge clk);
    bus.M_AWVALID[m] = 1'b0;
    if (!ok) return;
    for (int b = 0; b < nbeats; b++) begin
      while ($urandom_range(99) < bubble_pct) @(negedge clk);
      w = {(b == nbeats - 1), 32'($urandom())};
      exp_w[m].push_back(w);
      bus.M_W[m]      = w;
      bus.M_WVALID[m] = 1'b1;
      wait_hs(m, 1, ok);
      @(negedge clk);
      bus.M_WVALID[m] = 1'b0;
      if (!ok) return;
    end
    bus.M_BREADY[m] = 1'b1;
    wait_hs(m, 2, ok);
    @(negedge clk);
    bus.M_BREADY[m] = 1'b0;
  endtask

  task automatic run_master(input int m, input int ntxn);
    int len, nb;
    for (int t = 0; t < ntxn; t++) begin
      len = $urandom_range(0, 7);
      nb  = ($urandom_range(99) < 20) ? $urandom_range(1, len + 3) : len + 1;
      m_txn(m, $urandom(), 8'(len), nb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Slave agent and transaction-level monitor, sampled at negedge+1.
  initial begin : slave_and_monitor
    logic [1:0] prev_gnt, prev_req;
    int         last_owner, phase, beats, g, o;
    logic [7:0] cur_len;
    bit         err_exp, rel_exp, bpend, bdrop, ph0, ph1, ph2;
    prev_gnt = 0; prev_req = 0; last_owner = 1; phase = 0; beats = 0; cur_len = 0;
    err_exp = 0; rel_exp = 0; bpend = 0; bdrop = 0;
    bus.S_AWREADY = 0; bus.S_WREADY = 0; bus.S_BVALID = 0; bus.S_BRESP = 0;
    forever begin
      @(negedge clk);
      bus.S_AWREADY = ($urandom_range(99) < rdy_pct);
      bus.S_WREADY  = ($urandom_range(99) < rdy_pct);
      if (bdrop) begin
        bus.S_BVALID = 1'b0;
        bdrop        = 1'b0;
      end
      if (bpend && !bus.S_BVALID && $urandom_range(99) < rdy_pct) begin
        bus.S_BVALID = 1'b1;
        bus.S_BRESP  = 1'($urandom_range(1));
      end
      #1;
      if (reset) begin
        prev_gnt = 0; prev_req = 0; last_owner = 1; phase = 0;
        err_exp = 0; rel_exp = 0; bpend = 0; bdrop = 0;
        bus.S_BVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
          exp_aw[i].delete();
          exp_w[i].delete();
        end
        continue;
      end
      g = int'(gnt[1]);
      o = 1 - g;
      check("err", 64'(err), 64'(err_exp));
      err_exp = 1'b0;
      if (rel_exp) begin
        check("release", 64'(gnt), 64'd0);
        rel_exp = 1'b0;
      end
      if (prev_gnt == 2'b00) begin
        check("grant", 64'(gnt), 64'(pick(prev_req, last_owner)));
        if (gnt != 2'b00) begin
          owner_log.push_back(g);
          phase = 0;
        end
      end else if (gnt != 2'b00) begin
        check("owner_hold", 64'(gnt), 64'(prev_gnt));
      end
      if (gnt == 2'b00) begin
        check("idle_quiet", 64'({bus.S_AWVALID, bus.S_WVALID, bus.S_BREADY,
                                 bus.M_AWREADY, bus.M_WREADY, bus.M_BVALID}), 64'd0);
      end else begin
        ph0 = (phase == 0); ph1 = (phase == 1); ph2 = (phase == 2);
        check("iso", 64'({bus.M_AWREADY[o], bus.M_WREADY[o], bus.M_BVALID[o]}), 64'd0);
        check("fwd", 64'({bus.S_AWVALID, bus.M_AWREADY[g], bus.S_WVALID, bus.M_WREADY[g],
                          bus.S_BREADY, bus.M_BVALID[g]}),
              64'({ph0 & bus.M_AWVALID[g], ph0 & bus.S_AWREADY, ph1 & bus.M_WVALID[g],
                   ph1 & bus.S_WREADY, ph2 & bus.M_BREADY[g], ph2 & bus.S_BVALID}));
        if (ph2 && bus.S_BVALID) check("bresp", 64'(bus.M_BRESP[g]), 64'(bus.S_BRESP));
        if (ph0 && bus.M_AWVALID[g] && bus.S_AWREADY) begin
          check("aw_expected", 64'(exp_aw[g].size() > 0), 64'd1);
          if (exp_aw[g].size() > 0) check("aw", 64'(bus.S_AW), 64'(exp_aw[g].pop_front()));
          cur_len = bus.M_AW[g][12:5];
          beats   = 0;
          phase   = 1;
        end else if (ph1 && bus.M_WVALID[g] && bus.S_WREADY) begin
          check("w_expected", 64'(exp_w[g].size() > 0), 64'd1);
          if (exp_w[g].size() > 0) check("wdata", 64'(bus.S_W), 64'(exp_w[g].pop_front()));
          beats++;
          w_total++;
          if (bus.M_W[g][32]) begin
            err_exp = (beats != int'(cur_len) + 1);
            if (err_exp) err_cnt++;
            phase = 2;
            bpend = 1'b1;
          end
        end else if (ph2 && bus.S_BVALID && bus.M_BREADY[g]) begin
          rel_exp    = 1'b1;
          last_owner = g;
          bpend      = 1'b0;
          bdrop      = 1'b1;
        end
      end
      prev_gnt = gnt;
      prev_req = bus.M_AWVALID;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  w0, e0;
    bit  ok;
    logic [44:0] aw;
    logic [32:0] w;
    reset          = 1'b1;
    bus.M_AW       = '0;
    bus.M_W        = '0;
    bus.M_WVALID   = 2'b00;
    bus.M_BREADY   = 2'b11;
    bus.M_AWVALID  = 2'b11;   // requests during reset must not be granted

    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_s_ctl", 64'({bus.S_AWVALID, bus.S_WVALID, bus.S_BREADY}), 64'd0);
    check("rst_m_ctl", 64'({bus.M_AWREADY, bus.M_WREADY, bus.M_BVALID}), 64'd0);
    check("rst_s_aw", 64'(bus.S_AW), 64'd0);
    check("rst_s_w", 64'(bus.S_W), 64'd0);

    // Contention straight out of reset: M0 first, then M1 after one IDLE cycle.
    @(negedge clk);
    bus.M_BREADY = 2'b00;
    reset        = 1'b0;
    owner_log.delete();
    fork
      m_txn(0, 32'h100, 8'd1, 2);
      m_txn(1, 32'h200, 8'd0, 1);
    join
    repeat (2) @(negedge clk);
    check("c031_owners", 64'(owner_log.size()), 64'd2);
    if (owner_log.size() == 2) begin
      check("c031_first", 64'(owner_log[0]), 64'd0);
      check("c031_second", 64'(owner_log[1]), 64'd1);
    end

    // Single M0 burst: 4 beats at 0x10, no error.
    owner_log.delete();
    w0 = w_total; e0 = err_cnt;
    m_txn(0, 32'h10, 8'd3, 4);
    repeat (2) @(negedge clk);
    check("c030_beats", 64'(w_total - w0), 64'd4);
    check("c030_errs", 64'(err_cnt - e0), 64'd0);
    check("c030_owner", 64'(owner_log.size() == 1 && owner_log[0] == 0), 64'd1);

    // Early WLAST: LEN 3 with only 2 beats.
    e0 = err_cnt;
    m_txn(0, 32'h40, 8'd3, 2);
    repeat (2) @(negedge clk);
    check("c033_errs", 64'(err_cnt - e0), 64'd1);

    // Over-long burst: LEN 1 with 4 beats, all forwarded.
    w0 = w_total; e0 = err_cnt;
    m_txn(1, 32'h44, 8'd1, 4);
    repeat (2) @(negedge clk);
    check("long_beats", 64'(w_total - w0), 64'd4);
    check("long_errs", 64'(err_cnt - e0), 64'd1);

    // Reset in the middle of a data burst, then a fresh M1 request.
    aw = {32'h80, 8'd3, 3'd2, 2'd1};
    exp_aw[0].push_back(aw);
    bus.M_AW[0]      = aw;
    bus.M_AWVALID[0] = 1'b1;
    wait_hs(0, 0, ok);
    @(negedge clk);
    bus.M_AWVALID[0] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      w = {1'b0, 32'($urandom())};
      exp_w[0].push_back(w);
      bus.M_W[0]      = w;
      bus.M_WVALID[0] = 1'b1;
      wait_hs(0, 1, ok);
      @(negedge clk);
    end
    bus.M_W[0] = {1'b0, 32'($urandom())};
    reset      = 1'b1;
    #1;
    check("c034_gnt", 64'(gnt), 64'd0);
    check("c034_s_wvalid", 64'(bus.S_WVALID), 64'd0);
    check("c034_m_wready", 64'(bus.M_WREADY), 64'd0);
    @(negedge clk);
    reset           = 1'b0;
    bus.M_WVALID[0] = 1'b0;
    owner_log.delete();
    m_txn(1, 32'h300, 8'd2, 3);
    repeat (2) @(negedge clk);
    check("c034_regrant", 64'(owner_log.size() == 1 && owner_log[0] == 1), 64'd1);

    // Randomized contention with back-pressure and W bubbles.
    rdy_pct    = 65;
    bubble_pct = 25;
    fork
      run_master(0, 14);
      run_master(1, 14);
    join
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("sb_drained", 64'(exp_aw[i].size() + exp_w[i].size()), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter
Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning write data width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; ports `clk` and `reset` are listed first below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 M_AW  in  2x45  per-master {AWADDR[31:0],AWLEN[7:0],AWSIZE[2:0],AWBURST[1:0]}; master i occupies slice i.
REQ-007 M_AWVALID  in  2, and M_AWREADY  out  2: per-master write-address handshake.
REQ-008 M_W  in  2x33  per-master {WLAST,WDATA[31:0]}.
REQ-009 M_WVALID  in  2, and M_WREADY  out  2: per-master write-data handshake.
REQ-010 M_BRESP  out  2, M_BVALID  out  2, M_BREADY  in  2: per-master write response.
REQ-011 S_AW  out  45, S_AWVALID  out  1, S_AWREADY  in  1: slave write-address channel.
REQ-012 S_W  out  33, S_WVALID  out  1, S_WREADY  in  1: slave write-data channel.
REQ-013 S_BRESP  in  1, S_BVALID  in  1, S_BREADY  out  1: slave write-response channel.
REQ-014 GNT  out  2  one-hot current owner, all-zero when idle.
REQ-015 ERR  out  1  one-cycle pulse on WLAST/beat-count mismatch.
Function
REQ-016 SHALL implement FSM IDLE->ADDR->DATA->RESP->IDLE; one write transaction owns the slave from grant until the B handshake.
REQ-017 IDLE: if any M_AWVALID, grant registered next edge; priority to the master not granted last; pointer after reset favours M0.
REQ-018 Both requesting in the same cycle: grant per pointer; back-to-back contention SHALL alternate M0,M1,M0...
REQ-019 ADDR: S_AW/S_AWVALID = granted master's fields combinationally; M_AWREADY[gnt]=S_AWREADY; on S_AWVALID&&S_AWREADY capture AWLEN, go DATA.
REQ-020 DATA: S_W/S_WVALID from granted master, M_WREADY[gnt]=S_WREADY; 9-bit beat counter increments per W handshake.
REQ-021 DATA exit: W handshake with WLAST=1 -> RESP; ERR pulses if beat count != AWLEN+1 at WLAST; extra beats are forwarded, not dropped.
REQ-022 RESP: M_BVALID[gnt]=S_BVALID, M_BRESP[gnt]=S_BRESP, S_BREADY=M_BREADY[gnt]; on B handshake -> IDLE, pointer := gnt.
REQ-023 Non-granted master SHALL see AWREADY, WREADY, BVALID = 0; slave-side VALID/READY outputs SHALL be 0 outside their state.
REQ-024 Forwarding latency within a state SHALL be zero cycles; at least one IDLE cycle between transactions.
REQ-025 Master deasserting AWVALID in ADDR: stay in ADDR, no re-arbitration.
Reset
REQ-026 On reset: state IDLE, GNT=0, ERR=0, pointer favours M0, beat counter 0, all VALID/READY outputs 0, S_AW/S_W forced 0.
REQ-027 Reset mid-transaction SHALL abort immediately with no pending-grant memory after release.
Structure
REQ-028 FSM state encoding, field offsets of the 45-bit AW and 33-bit W bundles, and the BRESP OKAY constant SHALL live in shared package axi_pkg.
REQ-029 Round-robin selection SHALL be sub-module rr_arb2 (req[1:0], last, gnt[1:0]); the rest is flat.
Verification
REQ-030 M0 only: AWADDR 0x10, LEN 3, INCR, 4 beats -> S_AW=0x10, 4 beats forwarded, M_BVALID[0] pulse, GNT 01->00, ERR=0.
REQ-031 M0 and M1 both assert AWVALID in cycle 1 after reset -> M0 granted first, M1 granted after M0's B handshake plus one IDLE cycle.
REQ-032 M1 streams data while M0 waits -> M_WREADY[0]=0 and M_AWREADY[0]=0 throughout.
REQ-033 LEN 3 with WLAST on beat 2 -> ERR pulses one cycle, FSM enters RESP.
REQ-034 reset asserted in DATA after beat 2 -> next edge IDLE, GNT=0, S_WVALID=0; new M1 request is then granted normally.
